// File: rtl/mems_spi_arbiter_if.sv
// Bus bundle between the two DAC word requesters, the arbiter and the SPI master.
// The master modport is the arbiter side; slave is the requester/SPI-master side.
interface mems_spi_arbiter_if #(
  parameter int DATA_W = 24
);
  logic              scan_req;
  logic [DATA_W-1:0] scan_data;
  logic              scan_ack;
  logic              cfg_req;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_ack;
  logic              spi_start;
  logic [DATA_W-1:0] spi_data;
  logic              spi_busy;
  logic              grant_src;
  logic              arb_idle;

  modport master (
    input  scan_req, scan_data, cfg_req, cfg_data, spi_busy,
    output scan_ack, cfg_ack, spi_start, spi_data, grant_src, arb_idle
  );

  modport slave (
    output scan_req, scan_data, cfg_req, cfg_data, spi_busy,
    input  scan_ack, cfg_ack, spi_start, spi_data, grant_src, arb_idle
  );
endinterface

// File: rtl/mems_spi_arbiter.sv
// Two-way arbiter in front of the DAC SPI master. The scan stream and the
// configuration path share one SPI master; every grant produces one spi_start,
// transfers are separated by MIN_GAP idle cycles, and a pending configuration
// word is forced through after MAX_SCAN_BURST consecutive scan grants.
module mems_spi_arbiter #(
  parameter int DATA_W         = 24,
  parameter int MIN_GAP        = 16,
  parameter int MAX_SCAN_BURST = 8
) (
  input  logic               clk,
  input  logic               rst,
  mems_spi_arbiter_if.master bus
);

  localparam logic [7:0] GAP_LAST       = 8'(MIN_GAP - 1);
  localparam logic [7:0] BURST_LIM      = 8'(MAX_SCAN_BURST);
  localparam logic [7:0] STREAK_MAX     = 8'hFF;
  // WAIT_BUSY gives the SPI master three cycles to raise busy
  localparam logic [1:0] BUSY_WAIT_LAST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        streak_q, streak_d;
  logic [7:0]        gap_cnt_q, gap_cnt_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic              spi_start_q, spi_start_d;
  logic              scan_ack_q, scan_ack_d;
  logic              cfg_ack_q, cfg_ack_d;
  logic [DATA_W-1:0] spi_data_q, spi_data_d;
  logic              grant_src_q, grant_src_d;
  logic              arb_idle_q, arb_idle_d;
  logic              pick_cfg;

  // Next-state, grant decision and registered-output values
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    gap_cnt_d   = gap_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    spi_start_d = 1'b0;
    scan_ack_d  = 1'b0;
    cfg_ack_d   = 1'b0;
    spi_data_d  = spi_data_q;
    grant_src_d = grant_src_q;
    pick_cfg    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Streak only counts scan grants that made a pending config word wait
        if (!bus.cfg_req) begin
          streak_d = '0;
        end
        // A transfer still running in the SPI master (e.g. across a reset) blocks new starts
        if (!bus.spi_busy && (bus.scan_req || bus.cfg_req)) begin
          pick_cfg    = bus.cfg_req && (!bus.scan_req || (streak_q >= BURST_LIM));
          spi_start_d = 1'b1;
          grant_src_d = pick_cfg;
          state_d     = S_ISSUE;
          if (pick_cfg) begin
            cfg_ack_d  = 1'b1;
            spi_data_d = bus.cfg_data;
            streak_d   = '0;
          end else begin
            scan_ack_d = 1'b1;
            spi_data_d = bus.scan_data;
            if (bus.cfg_req && (streak_q != STREAK_MAX)) begin
              streak_d = streak_q + 8'd1;
            end
          end
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT_BUSY;
        wait_cnt_d = '0;
      end
      S_WAIT_BUSY: begin
        if (bus.spi_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wait_cnt_q == BUSY_WAIT_LAST) begin
          // Busy never showed up: treat the transfer as already finished
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.spi_busy) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    arb_idle_d = (state_d == S_IDLE) && !bus.spi_busy;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      gap_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      spi_start_q <= 1'b0;
      scan_ack_q  <= 1'b0;
      cfg_ack_q   <= 1'b0;
      spi_data_q  <= '0;
      grant_src_q <= 1'b0;
      arb_idle_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      gap_cnt_q   <= gap_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      spi_start_q <= spi_start_d;
      scan_ack_q  <= scan_ack_d;
      cfg_ack_q   <= cfg_ack_d;
      spi_data_q  <= spi_data_d;
      grant_src_q <= grant_src_d;
      arb_idle_q  <= arb_idle_d;
    end
  end

  assign bus.spi_start = spi_start_q;
  assign bus.scan_ack  = scan_ack_q;
  assign bus.cfg_ack   = cfg_ack_q;
  assign bus.spi_data  = spi_data_q;
  assign bus.grant_src = grant_src_q;
  assign bus.arb_idle  = arb_idle_q;

endmodule

// File: tb/tb_mems_spi_arbiter.sv
// Bench for mems_spi_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_mems_spi_arbiter;

  localparam int DATA_W         = 24;
  localparam int MIN_GAP        = 16;
  localparam int MAX_SCAN_BURST = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mems_spi_arbiter_if #(.DATA_W(DATA_W)) bus ();

  mems_spi_arbiter #(
    .DATA_W        (DATA_W),
    .MIN_GAP       (MIN_GAP),
    .MAX_SCAN_BURST(MAX_SCAN_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: first cycle at which the arbiter samples requests again,
  // scan streak, and the last granted word/source.
  int                ready    = 0;
  int                streak_m = 0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              exp_src  = 1'b0;

  // SPI master emulation: busy rises next_d cycles after start, lasts next_l cycles
  // (next_l = 0: busy never rises; negative: randomised per transfer)
  int busy_dly      = 0;
  int busy_rem      = 0;
  int cur_l         = 0;
  int busy_fall_cyc = 0;
  int next_d        = 1;
  int next_l        = 24;
  int last_start    = 0;

  // Requester behaviour on ack: continue with a fresh word, or drop the request
  bit scan_cont = 1'b0;
  bit cfg_cont  = 1'b0;

  function automatic logic [DATA_W-1:0] rnd_word();
    return DATA_W'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: sample inputs seen by the edge, compare outputs, then advance
  // the SPI master and requester emulation.
  task automatic tick();
    logic              s_scan, s_cfg, s_busy, s_rst;
    logic [DATA_W-1:0] s_sd, s_cd;
    logic              e_start, e_sack, e_cack, e_idle;
    bit                win_cfg;
    int                d, l, w;
    s_scan = bus.scan_req;
    s_cfg  = bus.cfg_req;
    s_busy = bus.spi_busy;
    s_rst  = rst;
    s_sd   = bus.scan_data;
    s_cd   = bus.cfg_data;
    @(posedge clk);
    #1;
    cyc++;
    e_sack  = 1'b0;
    e_cack  = 1'b0;
    e_start = 1'b0;
    d = 0;
    l = 0;
    w = 0;
    if (s_rst) begin
      ready    = cyc + 1;
      streak_m = 0;
      exp_data = '0;
      exp_src  = 1'b0;
      e_idle   = 1'b1;
    end else begin
      if (cyc >= ready && !s_cfg) streak_m = 0;
      e_start = (cyc >= ready) && !s_busy && (s_scan || s_cfg);
      if (e_start) begin
        win_cfg = s_cfg && (!s_scan || streak_m >= MAX_SCAN_BURST);
        if (win_cfg) begin
          streak_m = 0;
          exp_data = s_cd;
        end else begin
          if (s_cfg && streak_m < 255) streak_m++;
          exp_data = s_sd;
        end
        exp_src = win_cfg;
        e_sack  = !win_cfg;
        e_cack  = win_cfg;
      end
      e_idle = (cyc >= ready - 1) && !e_start && !s_busy;
    end

    chk("spi_start", 32'(bus.spi_start), 32'(e_start));
    chk("scan_ack", 32'(bus.scan_ack), 32'(e_sack));
    chk("cfg_ack", 32'(bus.cfg_ack), 32'(e_cack));
    chk("spi_data", 32'(bus.spi_data), 32'(exp_data));
    chk("grant_src", 32'(bus.grant_src), 32'(exp_src));
    chk("arb_idle", 32'(bus.arb_idle), 32'(e_idle));

    // SPI master emulation
    if (busy_dly > 0) begin
      busy_dly--;
      if (busy_dly == 0) begin
        bus.spi_busy = 1'b1;
        busy_rem     = cur_l;
      end
    end else if (bus.spi_busy) begin
      busy_rem--;
      if (busy_rem <= 0) begin
        bus.spi_busy  = 1'b0;
        busy_fall_cyc = cyc;
      end
    end

    if (e_start || bus.spi_start) begin
      d = (next_d > 0) ? next_d : int'($urandom_range(1, 3));
      if (next_l >= 0) l = next_l;
      else l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      w = (l > 0) ? d : 3;
      if (e_start) ready = cyc + 2 + w + l + MIN_GAP;
      if (bus.spi_start && l > 0) begin
        busy_dly = d;
        cur_l    = l;
      end
    end

    if (bus.spi_start) begin
      last_start = cyc;
      $display("txn cyc=%0d src=%s data=%06h", cyc, bus.grant_src ? "cfg" : "scan", bus.spi_data);
    end

    // Requesters react to their acks
    if (bus.scan_ack) begin
      if (scan_cont) bus.scan_data = rnd_word();
      else bus.scan_req = 1'b0;
    end
    if (bus.cfg_ack) begin
      if (cfg_cont) bus.cfg_data = rnd_word();
      else bus.cfg_req = 1'b0;
    end
  endtask

  task automatic wait_start(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.spi_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.arb_idle === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int s1;
    int n;
    rst           = 1'b1;
    bus.scan_req  = 1'b0;
    bus.scan_data = '0;
    bus.cfg_req   = 1'b0;
    bus.cfg_data  = '0;
    bus.spi_busy  = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("reset_arb_idle", 32'(bus.arb_idle), 32'd1);
    chk("reset_spi_data", 32'(bus.spi_data), 32'd0);
    rst = 1'b0;
    tick();

    // Single scan word with latency-1 start and MIN_GAP+1 spacing after busy falls
    next_d = 1;
    next_l = 24;
    bus.scan_req  = 1'b1;
    bus.scan_data = 24'hA5A5A5;
    tick();
    chk("single_start_latency", 32'(bus.spi_start), 32'd1);
    chk("single_scan_ack", 32'(bus.scan_ack), 32'd1);
    chk("single_spi_data", 32'(bus.spi_data), 32'hA5A5A5);
    chk("single_grant_src", 32'(bus.grant_src), 32'd0);
    bus.scan_req  = 1'b1;
    bus.scan_data = 24'h5A5A5A;
    wait_start("single_second_start", 200);
    chk("single_gap_spacing", 32'(last_start - (busy_fall_cyc + 1)), 32'(MIN_GAP + 1));
    wait_idle("single_idle", 200);

    // Starvation guard: continuous scan, config pending from the first grant
    next_d = 1;
    next_l = 4;
    scan_cont     = 1'b1;
    cfg_cont      = 1'b0;
    bus.scan_req  = 1'b1;
    bus.scan_data = rnd_word();
    bus.cfg_req   = 1'b1;
    bus.cfg_data  = 24'h300000;
    for (int g = 1; g <= MAX_SCAN_BURST + 2; g++) begin
      wait_start($sformatf("starve_start_%0d", g), 200);
      chk($sformatf("starve_src_%0d", g), 32'(bus.grant_src),
          32'(g == MAX_SCAN_BURST + 1));
    end
    scan_cont = 1'b0;
    wait_start("starve_tail", 200);
    wait_idle("starve_idle", 200);

    // Config only
    bus.cfg_req  = 1'b1;
    bus.cfg_data = 24'h280001;
    wait_start("cfg_start", 50);
    chk("cfg_ack", 32'(bus.cfg_ack), 32'd1);
    chk("cfg_no_scan_ack", 32'(bus.scan_ack), 32'd0);
    chk("cfg_spi_data", 32'(bus.spi_data), 32'h280001);
    chk("cfg_grant_src", 32'(bus.grant_src), 32'd1);
    wait_idle("cfg_idle", 200);

    // SPI master never raises busy
    next_l = 0;
    bus.scan_req  = 1'b1;
    bus.scan_data = rnd_word();
    wait_start("nobusy_first", 50);
    s1 = last_start;
    bus.scan_req  = 1'b1;
    bus.scan_data = rnd_word();
    wait_start("nobusy_second", 200);
    chk("nobusy_spacing", 32'(last_start - s1), 32'(MIN_GAP + 5));
    wait_idle("nobusy_idle", 200);

    // Reset in the middle of a transfer, busy held 10 more cycles
    next_d = 1;
    next_l = 40;
    bus.scan_req  = 1'b1;
    bus.scan_data = rnd_word();
    wait_start("rstbusy_start", 50);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_rem = 10;
    chk("rstbusy_spi_start", 32'(bus.spi_start), 32'd0);
    chk("rstbusy_spi_data", 32'(bus.spi_data), 32'd0);
    chk("rstbusy_grant_src", 32'(bus.grant_src), 32'd0);
    chk("rstbusy_arb_idle", 32'(bus.arb_idle), 32'd1);
    next_l = 4;
    bus.scan_req  = 1'b1;
    bus.scan_data = rnd_word();
    wait_start("rstbusy_restart", 40);
    chk("rstbusy_restart_delay", 32'(last_start - busy_fall_cyc), 32'd1);
    wait_idle("rstbusy_idle", 200);

    // Request raised during a transfer and dropped during GAP
    bus.scan_req  = 1'b1;
    bus.scan_data = rnd_word();
    wait_start("drop_first", 50);
    bus.scan_req  = 1'b1;
    bus.scan_data = rnd_word();
    repeat (12) tick();
    bus.scan_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.spi_start === 1'b1 || bus.scan_ack === 1'b1) n++;
    end
    chk("drop_no_ack", 32'(n), 32'd0);
    chk("drop_arb_idle", 32'(bus.arb_idle), 32'd1);

    // Random traffic against the model
    next_d = -1;
    next_l = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      scan_cont = ($urandom_range(0, 3) != 0);
      cfg_cont  = ($urandom_range(0, 7) == 0);
      if (!bus.scan_req) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.scan_req  = 1'b1;
          bus.scan_data = rnd_word();
        end
      end else if ($urandom_range(0, 63) == 0) begin
        bus.scan_req = 1'b0;
      end
      if (!bus.cfg_req) begin
        if ($urandom_range(0, 5) == 0) begin
          bus.cfg_req  = 1'b1;
          bus.cfg_data = rnd_word();
        end
      end else if ($urandom_range(0, 63) == 0) begin
        bus.cfg_req = 1'b0;
      end
    end
    bus.scan_req = 1'b0;
    bus.cfg_req  = 1'b0;
    repeat (60) tick();
    chk("final_arb_idle", 32'(bus.arb_idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mems_spi_arbiter.md
# mems_spi_arbiter

Shares the single DAC SPI master between two requesters: the scan sequencer, which streams MEMS mirror waveform words, and the configuration path, which issues software-reset, VREF and gain commands. The block sits between both requesters and the SPI master. It issues one `spi_start` per granted word and enforces a minimum inter-transfer gap that paces the scan. It also guarantees the configuration path cannot be starved by a continuous scan stream.

## Interface
- `DATA_W`, 24: width of one DAC SPI word.
- `MIN_GAP`, 16: idle cycles between `spi_busy` falling and the next `spi_start`; legal range 1..255.
- `MAX_SCAN_BURST`, 8: consecutive scan grants allowed while `cfg_req` is pending before configuration is forced through; legal range 1..255.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `scan_req`  in  1  level; scan word pending.
- `scan_data`  in  DATA_W  held stable while `scan_req`=1.
- `scan_ack`  out  1  one-cycle pulse; scan word accepted.
- `cfg_req`  in  1  level; config word pending.
- `cfg_data`  in  DATA_W  held stable while `cfg_req`=1.
- `cfg_ack`  out  1  one-cycle pulse; config word accepted.
- `spi_start`  out  1  one-cycle pulse to the SPI master.
- `spi_data`  out  DATA_W  word for the SPI master; valid when `spi_start`=1 and held until the next grant.
- `spi_busy`  in  1  SPI master busy.
- `grant_src`  out  1  source of the last grant: 0 = scan, 1 = config.
- `arb_idle`  out  1  high in IDLE with no transfer outstanding.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:**
  - Stays in IDLE while `spi_busy`=1 or no request is pending.
  - Otherwise selects a winner, latches its data into `spi_data`, and goes to ISSUE.
- **Winner selection:**
  - Only one request pending: that requester wins.
  - Both pending: scan wins if `streak` < `MAX_SCAN_BURST`; otherwise config wins.
- **streak counter** (8-bit, saturating):
  - Increments on each scan grant made while `cfg_req`=1.
  - Clears on a config grant, and in any IDLE cycle where `cfg_req`=0.
- **ISSUE** (exactly 1 cycle):
  - `spi_start`=1, and the winner's ack is 1 in the same cycle.
  - `grant_src` updates in the same cycle.
  - Next state: WAIT_BUSY.
- **WAIT_BUSY:**
  - Goes to WAIT_DONE when `spi_busy`=1.
  - If `spi_busy` is not seen within 3 cycles, the transfer is treated as already complete and the FSM goes to GAP.
- **WAIT_DONE:** goes to GAP on the first cycle with `spi_busy`=0.
- **GAP:**
  - Counts `MIN_GAP` cycles, then returns to IDLE.
  - Requests arriving during a transfer or gap are held by the requester and are not acknowledged early.
- **Requester rule:** a requester may change its data or drop its request only after its ack. Dropping a request before its ack is allowed; that request is simply not granted.
- **Reset:**
  - State goes to IDLE; `streak`=0; `gap_cnt`=0.
  - `spi_start`=0, `scan_ack`=0, `cfg_ack`=0, `spi_data`=0, `grant_src`=0, `arb_idle`=1.
  - Reset does not abort a transfer already running in the SPI master. The IDLE busy check ensures no start is issued until that transfer finishes.

## Timing
- **Request to start:** a request sampled in IDLE with `spi_busy`=0 produces `spi_start` and ack on the next cycle (latency 1).
- **Back-to-back throughput:** start-to-start spacing = 1 (ISSUE) + busy-wait + busy duration + `MIN_GAP` + 1 (IDLE).
- **arb_idle:** registered; high only in IDLE and only while `spi_busy`=0.
- **Simultaneous events:**
  - A request rising in the same cycle that GAP expires is seen in the following IDLE cycle.
  - Both requests rising in the same cycle with `streak`=0 → scan wins.
- **Widths:** `gap_cnt` is 8 bits and compares against `MIN_GAP`-1. `streak` saturates at 255 and never wraps.

## Test plan
- **Single scan word:** `scan_req`=1 with `scan_data`=0xA5A5A5, idle SPI master that asserts busy 1 cycle after start for 24 cycles → `spi_start` and `scan_ack` 1 cycle after the request, `spi_data`=0xA5A5A5, `grant_src`=0; next start exactly `MIN_GAP`+1 cycles after busy falls.
- **Starvation guard:** `scan_req` held high continuously, `cfg_req` raised before the first grant, `MAX_SCAN_BURST`=8 → grants 1–8 go to scan, grant 9 to config (`cfg_ack` pulse, `grant_src`=1), grant 10 to scan.
- **Config only:** `cfg_req`=1 with `cfg_data`=0x280001 → `cfg_ack` and `spi_data`=0x280001; `streak` stays 0.
- **Missing busy:** SPI master never asserts `spi_busy` → FSM leaves WAIT_BUSY after 3 cycles, completes GAP, and serves the next request.
- **Reset with busy held:** pulse `rst` mid-transfer while `spi_busy` stays 1 for 10 more cycles → all outputs take their reset values; no `spi_start` until busy falls; the first start follows 1 cycle after.
- **Dropped request:** `scan_req` deasserted during GAP → no `scan_ack`; `arb_idle`=1 after GAP.
